int_sequencer: RTL
==================

// Module: int_sequencer
// PURPOSE
// Interrupt/reset scheduler in front of the opcode decoder. Arbitrates RES, NMI, IRQ and software BRK,
// injects opcode 8'h00 into the decode path at instruction boundaries, and sequences the 6-cycle
// stack-push / vector-fetch tail, supplying the interrupt kind, the B flag value and the vector address.
// PARAMETERS
// SYNC_STAGES  2        flops in the nmi_n/irq_n synchronisers (>=2)
// VEC_NMI      16'hFFFA NMI vector low-byte address
// VEC_RES      16'hFFFC reset vector low-byte address
// VEC_IRQ      16'hFFFE IRQ/BRK vector low-byte address
// PORTS
// clk            in   1   core clock
// rst_n          in   1   async active-low reset
// nmi_n          in   1   async NMI line, falling-edge sensitive
// irq_n          in   1   async IRQ line, level sensitive, active low
// i_flag         in   1   status I (interrupt disable)
// sync           in   1   opcode fetch cycle (instruction boundary)
// fetched_op     in   8   opcode byte from the data bus
// op_out         out  8   opcode driven to decode
// int_active     out  1   interrupt/BRK/reset tail in progress
// int_kind       out  2   00 BRK, 01 IRQ, 10 NMI, 11 RES
// seq_step       out  3   tail step 1..6, 0 when idle
// vec_addr       out  16  vector low-byte address (valid steps 5-6)
// push_b         out  1   B value to push with P (1 only for BRK)
// pc_hold        out  1   inhibit PC increment on this fetch
// suppress_write out  1   stack pushes become reads (reset tail)
// BEHAVIOUR
// - Reset (rst_n low, async): op_out=8'h00, int_active=1, int_kind=11, seq_step=0, vec_addr=VEC_RES,
//   push_b=0, pc_hold=1, suppress_write=1, pending flags and NMI edge history cleared (nmi_prev=1).
// - First clk after rst_n release: RES tail starts without waiting for sync; seq_step 1..6.
// - States: IDLE, TAIL. TAIL lasts exactly 6 cycles (seq_step 1..6), then IDLE with seq_step=0.
// - NMI: falling edge of synchronised nmi_n sets nmi_pend (SYNC_STAGES+1 cycles after pin edge).
//   Held-low nmi_n yields one service; a new one requires a rising then falling edge.
// - IRQ: irq_req = synchronised ~irq_n & ~i_flag, evaluated combinationally at sync; not latched.
// - IDLE & sync: priority NMI > IRQ > BRK. If nmi_pend|irq_req: op_out=8'h00, pc_hold=1, enter TAIL
//   with kind 10/01, push_b=0. Else op_out=fetched_op, pc_hold=0; if fetched_op==8'h00 enter TAIL with
//   kind 00, push_b=1. Otherwise stay IDLE.
// - op_out is combinational: fetched_op in IDLE except on injection; 8'h00 during TAIL.
// - vec_addr from kind at entry: NMI->VEC_NMI, RES->VEC_RES, IRQ/BRK->VEC_IRQ. nmi_pend cleared at
//   step 5 only if kind=NMI at that point (or hijacked, see below).
// - sync asserted during TAIL is ignored. NMI edges during TAIL still set nmi_pend.
// - int_active=1 throughout TAIL, 0 in IDLE. suppress_write=1 only in RES tail; 0 after step 6.
// - push_b holds its entry value until next TAIL entry. pc_hold=0 outside injected fetch and reset.
// - rst_n asserted mid-TAIL: abort immediately to reset values; nmi_pend lost.
// CONFIGURATION
// INT_HIJACK_EN defined: in IRQ/BRK TAIL, nmi_pend set at or before step 4 switches kind to 10 and
//   vec_addr to VEC_NMI from step 5; push_b unchanged; nmi_pend cleared at step 5.
// INT_HIJACK_EN undefined: vector fixed at entry; late NMI stays pending, serviced at next sync.
// TESTING
// 1 rst_n low 3 clk, release -> kind=11, suppress_write=1, seq_step 1..6, vec_addr=FFFC, then IDLE, int_active=0.
// 2 irq_n low, i_flag=0, sync with fetched_op=A9 -> op_out=00, pc_hold=1, kind=01, push_b=0, vec FFFE;
//   repeat with i_flag=1 -> op_out=A9, no TAIL.
// 3 nmi_n falls and stays low -> one TAIL kind=10, vec FFFA; next syncs pass opcodes; rise+fall -> second TAIL.
// 4 sync, fetched_op=00, nothing pending -> op_out=00, pc_hold=0, kind=00, push_b=1, vec FFFE.
// 5 BRK TAIL, NMI edge pending by step 3 -> EN: vec FFFA at step 5, push_b=1; not EN: vec FFFE, NMI TAIL at next sync.
// 6 NMI pending and irq_n low at same sync -> kind=10 first; rst_n low at step 3 -> reset values at once.

Source files
------------

// File: rtl/int_sequencer_if.sv
// -----------------------------------------------------------------------------
// int_sequencer_if
// Decode-path bundle between the CPU core and the interrupt sequencer.
//   i_flag         core -> seq   status I (interrupt disable)
//   sync           core -> seq   opcode fetch cycle (instruction boundary)
//   fetched_op     core -> seq   opcode byte from the data bus
//   op_out         seq  -> core  opcode driven to decode
//   int_active     seq  -> core  interrupt/BRK/reset tail in progress
//   int_kind       seq  -> core  00 BRK, 01 IRQ, 10 NMI, 11 RES
//   seq_step       seq  -> core  tail step 1..6, 0 when idle
//   vec_addr       seq  -> core  vector low-byte address (valid steps 5-6)
//   push_b         seq  -> core  B value pushed with P
//   pc_hold        seq  -> core  inhibit PC increment on this fetch
//   suppress_write seq  -> core  stack pushes become reads (reset tail)
// Modports: master = core side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface int_sequencer_if;
   logic        i_flag;
   logic        sync;
   logic [7:0]  fetched_op;
   logic [7:0]  op_out;
   logic        int_active;
   logic [1:0]  int_kind;
   logic [2:0]  seq_step;
   logic [15:0] vec_addr;
   logic        push_b;
   logic        pc_hold;
   logic        suppress_write;

   modport master (
      output i_flag, sync, fetched_op,
      input  op_out, int_active, int_kind, seq_step, vec_addr,
             push_b, pc_hold, suppress_write
   );

   modport slave (
      input  i_flag, sync, fetched_op,
      output op_out, int_active, int_kind, seq_step, vec_addr,
             push_b, pc_hold, suppress_write
   );
endinterface

// File: rtl/int_sequencer.sv
// -----------------------------------------------------------------------------
// int_sequencer
// Interrupt/reset scheduler in front of the opcode decoder. Arbitrates RES,
// NMI, IRQ and software BRK, injects opcode 8'h00 at instruction boundaries and
// sequences the 6-cycle push / vector-fetch tail.
// Ports:
//   clk    core clock
//   rst_n  asynchronous active-low reset
//   nmi_n  asynchronous NMI pin, falling-edge sensitive
//   irq_n  asynchronous IRQ pin, level sensitive, active low
//   bus    int_sequencer_if.slave (decode-path bundle, see interface header)
// Build option:
//   INT_HIJACK_EN  when defined, an NMI pending by step 4 of an IRQ/BRK tail
//                  takes over the vector from step 5 onwards.
// -----------------------------------------------------------------------------
module int_sequencer #(
   parameter int          SYNC_STAGES = 2,
   parameter logic [15:0] VEC_NMI     = 16'hFFFA,
   parameter logic [15:0] VEC_RES     = 16'hFFFC,
   parameter logic [15:0] VEC_IRQ     = 16'hFFFE
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           nmi_n,
   input  logic           irq_n,
   int_sequencer_if.slave bus
);

   localparam logic [1:0] KIND_BRK = 2'b00;
   localparam logic [1:0] KIND_IRQ = 2'b01;
   localparam logic [1:0] KIND_NMI = 2'b10;
   localparam logic [1:0] KIND_RES = 2'b11;

   typedef enum logic {IDLE, TAIL} state_t;

   // ------------------------------------------------------------------
   // Pin synchronisers (idle-high so reset never looks like an edge)
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] nmi_sync_reg, nmi_sync_next;
   logic [SYNC_STAGES-1:0] irq_sync_reg, irq_sync_next;

   assign nmi_sync_next[0] = nmi_n;
   assign irq_sync_next[0] = irq_n;

   genvar gi;
   generate
      for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
         assign nmi_sync_next[gi] = nmi_sync_reg[gi-1];
         assign irq_sync_next[gi] = irq_sync_reg[gi-1];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nmi_sync_reg <= '1;
         irq_sync_reg <= '1;
      end else begin
         nmi_sync_reg <= nmi_sync_next;
         irq_sync_reg <= irq_sync_next;
      end
   end

   logic nmi_s;
   logic irq_s;
   assign nmi_s = nmi_sync_reg[SYNC_STAGES-1];
   assign irq_s = irq_sync_reg[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Sequencer state
   // ------------------------------------------------------------------
   state_t      state_reg,    state_next;
   logic [2:0]  step_reg,     step_next;
   logic [1:0]  kind_reg,     kind_next;
   logic [15:0] vec_reg,      vec_next;
   logic        push_b_reg,   push_b_next;
   logic        suppress_reg, suppress_next;
   logic        nmi_pend_reg, nmi_pend_next;
   logic        nmi_prev_reg;

   logic       nmi_fall;
   logic       irq_req;
   logic [7:0] op_out_c;
   logic       pc_hold_c;
   logic       int_active_c;

   assign nmi_fall = nmi_prev_reg & ~nmi_s;
   // IRQ is a level request qualified by I; it is only sampled at sync.
   assign irq_req  = ~irq_s & ~bus.i_flag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // Reset parks in TAIL at step 0 so the RES tail starts on the
         // first clock after release without waiting for sync.
         state_reg    <= TAIL;
         step_reg     <= 3'd0;
         kind_reg     <= KIND_RES;
         vec_reg      <= VEC_RES;
         push_b_reg   <= 1'b0;
         suppress_reg <= 1'b1;
         nmi_pend_reg <= 1'b0;
         nmi_prev_reg <= 1'b1;
      end else begin
         state_reg    <= state_next;
         step_reg     <= step_next;
         kind_reg     <= kind_next;
         vec_reg      <= vec_next;
         push_b_reg   <= push_b_next;
         suppress_reg <= suppress_next;
         nmi_pend_reg <= nmi_pend_next;
         nmi_prev_reg <= nmi_s;
      end
   end

   always_comb begin
      state_next    = state_reg;
      step_next     = step_reg;
      kind_next     = kind_reg;
      vec_next      = vec_reg;
      push_b_next   = push_b_reg;
      suppress_next = suppress_reg;
      nmi_pend_next = nmi_pend_reg;
      op_out_c      = bus.fetched_op;
      pc_hold_c     = 1'b0;
      int_active_c  = 1'b0;

      case (state_reg)
         IDLE: begin
            if (bus.sync) begin
               if (nmi_pend_reg || irq_req) begin
                  // Hardware interrupt: replace the fetched opcode with BRK
                  // and keep PC pointing at the interrupted instruction.
                  op_out_c      = 8'h00;
                  pc_hold_c     = 1'b1;
                  state_next    = TAIL;
                  step_next     = 3'd1;
                  kind_next     = nmi_pend_reg ? KIND_NMI : KIND_IRQ;
                  vec_next      = nmi_pend_reg ? VEC_NMI : VEC_IRQ;
                  push_b_next   = 1'b0;
                  suppress_next = 1'b0;
               end else if (bus.fetched_op == 8'h00) begin
                  state_next    = TAIL;
                  step_next     = 3'd1;
                  kind_next     = KIND_BRK;
                  vec_next      = VEC_IRQ;
                  push_b_next   = 1'b1;
                  suppress_next = 1'b0;
               end
            end
         end

         TAIL: begin
            op_out_c     = 8'h00;
            int_active_c = 1'b1;
            pc_hold_c    = (kind_reg == KIND_RES);
            if (step_reg == 3'd6) begin
               state_next    = IDLE;
               step_next     = 3'd0;
               suppress_next = 1'b0;
            end else begin
               step_next = step_reg + 3'd1;
               // Leaving step 4 is the last moment the vector can change;
               // the NMI request is consumed here when it is being served.
               if (step_reg == 3'd4) begin
                  if (kind_reg == KIND_NMI) begin
                     nmi_pend_next = 1'b0;
                  end
`ifdef INT_HIJACK_EN
                  else if (nmi_pend_reg && (kind_reg != KIND_RES)) begin
                     kind_next     = KIND_NMI;
                     vec_next      = VEC_NMI;
                     nmi_pend_next = 1'b0;
                  end
`endif
               end
            end
         end

         default: begin
            state_next = IDLE;
            step_next  = 3'd0;
         end
      endcase

      // A fresh edge always wins over a same-cycle clear.
      if (nmi_fall) begin
         nmi_pend_next = 1'b1;
      end
   end

   assign bus.op_out         = op_out_c;
   assign bus.pc_hold        = pc_hold_c;
   assign bus.int_active     = int_active_c;
   assign bus.int_kind       = kind_reg;
   assign bus.seq_step       = step_reg;
   assign bus.vec_addr       = vec_reg;
   assign bus.push_b         = push_b_reg;
   assign bus.suppress_write = suppress_reg;

endmodule
